concatenador_numeros: RTL and testbench
=======================================

# concatenador_numeros

Accumulates a stream of decimal digits, most significant first, into a 32-bit binary integer. Each accepted digit updates the accumulator to `acc*10 + digit`. A `fin` strobe publishes the accumulated value on `resultado` and clears the accumulator for the next number. The block sits behind the UART receive path, between digit decoding and the arithmetic/command logic that consumes whole operands.

## Interface
- Clocking: one clock; reset is synchronous and active-high.
- `RES_W`, default 32: width of `resultado` and of the accumulator.
- `DATO_W`, default 8: width of `dato`.
- `clk`  in  1  system clock; all logic samples on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dato`  in  DATO_W  digit value; valid while `num_ready` is high.
- `num_ready`  in  1  digit strobe; only its rising edge is significant.
- `fin`  in  1  end-of-number strobe; only its rising edge is significant.
- `resultado`  out  RES_W  last published number; holds its value between publications.
- `listo`  out  1  one-cycle pulse in the cycle after `resultado` updates.
- `desborde`  out  1  overflow flag for the number currently on `resultado`.

## Operation
- Edge detection:
  - Registered copies `num_ready_q` and `fin_q` give `dig_ev = num_ready & ~num_ready_q` and `fin_ev = fin & ~fin_q`.
  - A level held for N cycles counts as one event.
- Digit validity: `dato` in 0..9 is a digit; any other value is ignored when `dig_ev` fires (no state change).
- On `dig_ev` with a valid digit:
  - `acc <= (acc<<3) + (acc<<1) + digit`, computed at RES_W+4 bits and truncated to RES_W.
  - If any discarded upper bit is nonzero, the sticky `ovf_acc` is set.
- On `fin_ev`:
  - `resultado <= acc_next` and `desborde <= ovf_next`, where `acc_next`/`ovf_next` include a digit accepted in the same cycle.
  - `acc <= 0`, `ovf_acc <= 0`.
  - `listo` pulses high for one cycle.
- `fin_ev` with no digits since the last clear publishes 0.
- Reset: `acc`, `ovf_acc`, `num_ready_q`, `fin_q`, `resultado`, `listo` and `desborde` all go to 0. Reset has priority over all events, including reset arriving mid-number.
- No maximum digit count; wrap-around is modulo 2^RES_W, flagged by `desborde`.

## Timing
- A digit is accepted at the first rising clock edge where `num_ready` is 1 and was 0 at the previous edge. The accumulator shows the new value one cycle later.
- `resultado` and `desborde` update at the edge where `fin_ev` is detected. `listo` is high during the following cycle.
- Minimum digit rate: one digit every 2 cycles, since `num_ready` must return low for at least one cycle between digits.
- `dato` must be stable at the edge where `dig_ev` is detected.

## Configuration
- `CONCAT_ASCII_EN`:
  - Defined: `dato` values 0x30..0x39 are also accepted as digits 0..9, mapped by `dato - 8'h30`.
  - Undefined: only raw values 0..9 are accepted; ASCII codes are ignored like any other non-digit.

## Structure
- Shared package `concat_pkg` holds:
  - `BASE = 10`
  - `ASCII_CERO = 8'h30`
  - `RES_W_DEF = 32`
  - digit typedef `digito_t` (4-bit)
- Natural sub-module `detector_flanco`: one-bit rising-edge detector with synchronous reset, instantiated twice (for `num_ready` and `fin`).
- Top level holds digit decode, ×10 accumulator and output registers.

## Test plan
- Digits 9,8,1,4,9,8,1,4,9, each `num_ready` pulse one cycle wide with one idle cycle between pulses, then `fin` → `resultado = 981498149`, `desborde = 0`, one `listo` pulse.
- Following number 1,1,1,7,7,5,3,4,4 then `fin` → `resultado = 111775344`. The first number is held unchanged until that `fin`.
- `num_ready` held high 5 cycles with `dato = 7`, then `fin` → `resultado = 7` (single acceptance). `fin` with no digits → `resultado = 0`.
- Digits 4,2,9,4,9,6,7,2,9,6 then `fin` → `resultado = 0` (4294967296 mod 2^32), `desborde = 1`. The next number publishes with `desborde = 0`.
- `dato = 8'h35` strobed, then `fin`:
  - with `CONCAT_ASCII_EN` → `resultado = 5`;
  - without it → `resultado = 0`.
  - `dato = 12` is ignored in both builds.
- Reset asserted after digits 3,6: all outputs 0 next cycle. Then digit 2 and `fin` → `resultado = 2`.

Source files
------------

// File: rtl/concatenador_numeros_pkg.sv
// Shared constants and types for the decimal digit accumulator.
// The optional CONCAT_ASCII_EN build macro is consumed by concatenador_numeros.
package concat_pkg;

    localparam int          BASE       = 10;
    localparam logic [7:0]  ASCII_CERO = 8'h30;
    localparam int          RES_W_DEF  = 32;

    typedef logic [3:0] digito_t;

endpackage

// File: rtl/concatenador_numeros_detector_flanco.sv
// One-bit rising-edge detector: flags the first cycle a level is seen high.
module detector_flanco (
    input  logic clk,
    input  logic reset,
    input  logic nivel,
    output logic flanco
);

    logic nivel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            nivel_q <= 1'b0;
        end else begin
            nivel_q <= nivel;
        end
    end

    assign flanco = nivel & ~nivel_q;

endmodule

// File: rtl/concatenador_numeros.sv
// Decimal digit stream (MSD first) to binary integer accumulator.
// Build macro CONCAT_ASCII_EN additionally accepts ASCII '0'..'9' as digits.
module concatenador_numeros
    import concat_pkg::*;
#(
    parameter int RES_W  = RES_W_DEF,
    parameter int DATO_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATO_W-1:0] dato,
    input  logic              num_ready,
    input  logic              fin,
    output logic [RES_W-1:0]  resultado,
    output logic              listo,
    output logic              desborde
);

    logic dig_ev;
    logic fin_ev;

    detector_flanco u_flanco_num (
        .clk    (clk),
        .reset  (reset),
        .nivel  (num_ready),
        .flanco (dig_ev)
    );

    detector_flanco u_flanco_fin (
        .clk    (clk),
        .reset  (reset),
        .nivel  (fin),
        .flanco (fin_ev)
    );

    // Digit decode: anything that is not a digit leaves the state untouched.
    digito_t digito;
    logic    valido;

    always_comb begin
        digito = '0;
        valido = 1'b0;
        if (dato < DATO_W'(BASE)) begin
            valido = 1'b1;
            digito = digito_t'(dato);
        end
`ifdef CONCAT_ASCII_EN
        else if (dato >= DATO_W'(ASCII_CERO) &&
                 dato <= DATO_W'(ASCII_CERO + 8'd9)) begin
            valido = 1'b1;
            digito = digito_t'(dato - DATO_W'(ASCII_CERO));
        end
`endif
    end

    logic [RES_W-1:0] acc;
    logic             ovf_acc;
    logic [RES_W+3:0] acc_ancho;
    logic [RES_W+3:0] prod;
    logic [RES_W-1:0] acc_next;
    logic             ovf_next;

    // acc*10 + digit never exceeds 16*2^RES_W, so four guard bits catch every overflow.
    always_comb begin
        acc_ancho = {4'b0000, acc};
        prod      = (acc_ancho << 3) + (acc_ancho << 1) + {{RES_W{1'b0}}, digito};
        acc_next  = acc;
        ovf_next  = ovf_acc;
        if (dig_ev && valido) begin
            acc_next = prod[RES_W-1:0];
            ovf_next = ovf_acc | (|prod[RES_W+3:RES_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            ovf_acc   <= 1'b0;
            resultado <= '0;
            desborde  <= 1'b0;
            listo     <= 1'b0;
        end else begin
            listo <= fin_ev;
            if (fin_ev) begin
                resultado <= acc_next;
                desborde  <= ovf_next;
                acc       <= '0;
                ovf_acc   <= 1'b0;
            end else begin
                acc     <= acc_next;
                ovf_acc <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_concatenador_numeros.sv
// Directed bench for concatenador_numeros; honours CONCAT_ASCII_EN like the RTL.
module tb_concatenador_numeros;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  dato;
    logic        num_ready;
    logic        fin;
    logic [31:0] resultado;
    logic        listo;
    logic        desborde;

    int checks = 0;
    int errors = 0;

    concatenador_numeros dut (
        .clk       (clk),
        .reset     (reset),
        .dato      (dato),
        .num_ready (num_ready),
        .fin       (fin),
        .resultado (resultado),
        .listo     (listo),
        .desborde  (desborde)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic digit(input logic [7:0] d);
        dato      = d;
        num_ready = 1'b1;
        tick();
        num_ready = 1'b0;
        tick();
    endtask

    // fin held three cycles must still give exactly one listo pulse
    task automatic publish(input string tag, input logic [31:0] exp_r, input logic exp_d);
        int pulses;
        pulses = 0;
        fin = 1'b1;
        repeat (3) begin
            tick();
            pulses += int'(listo);
        end
        fin = 1'b0;
        tick();
        pulses += int'(listo);
        chk({tag, "_resultado"}, resultado, exp_r);
        chk({tag, "_desborde"}, 32'(desborde), 32'(exp_d));
        chk({tag, "_listo_pulses"}, 32'(pulses), 32'd1);
    endtask

    initial begin
        int n1[9]  = '{9, 8, 1, 4, 9, 8, 1, 4, 9};
        int n2[9]  = '{1, 1, 1, 7, 7, 5, 3, 4, 4};
        int n3[10] = '{4, 2, 9, 4, 9, 6, 7, 2, 9, 6};

        reset     = 1'b1;
        dato      = '0;
        num_ready = 1'b0;
        fin       = 1'b0;
        tick();
        tick();
        chk("reset_resultado", resultado, 32'd0);
        chk("reset_listo", 32'(listo), 32'd0);
        chk("reset_desborde", 32'(desborde), 32'd0);
        reset = 1'b0;
        tick();

        foreach (n1[i]) digit(8'(n1[i]));
        publish("num1", 32'd981498149, 1'b0);

        foreach (n2[i]) digit(8'(n2[i]));
        chk("num1_held", resultado, 32'd981498149);
        publish("num2", 32'd111775344, 1'b0);

        // level held five cycles is a single digit
        dato      = 8'd7;
        num_ready = 1'b1;
        repeat (5) tick();
        num_ready = 1'b0;
        tick();
        publish("held7", 32'd7, 1'b0);
        publish("empty", 32'd0, 1'b0);

        foreach (n3[i]) digit(8'(n3[i]));
        publish("wrap", 32'd0, 1'b1);
        digit(8'd8);
        publish("after_wrap", 32'd8, 1'b0);

        digit(8'h35);
`ifdef CONCAT_ASCII_EN
        publish("ascii5", 32'd5, 1'b0);
`else
        publish("ascii5", 32'd0, 1'b0);
`endif

        digit(8'd3);
        digit(8'd12);
        digit(8'd4);
        publish("skip12", 32'd34, 1'b0);

        // digit strobe and fin on the same edge: the digit is included
        digit(8'd4);
        dato      = 8'd5;
        num_ready = 1'b1;
        fin       = 1'b1;
        tick();
        chk("same_edge_resultado", resultado, 32'd45);
        chk("same_edge_listo", 32'(listo), 32'd1);
        num_ready = 1'b0;
        fin       = 1'b0;
        tick();
        chk("same_edge_listo_low", 32'(listo), 32'd0);
        publish("same_edge_cleared", 32'd0, 1'b0);

        // reset mid-number wipes outputs and the partial accumulator
        digit(8'd9);
        publish("pre_reset", 32'd9, 1'b0);
        digit(8'd3);
        digit(8'd6);
        reset = 1'b1;
        tick();
        chk("midreset_resultado", resultado, 32'd0);
        chk("midreset_listo", 32'(listo), 32'd0);
        chk("midreset_desborde", 32'(desborde), 32'd0);
        reset = 1'b0;
        tick();
        digit(8'd2);
        publish("post_reset", 32'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
